// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl: sequencer for the dot-product datapath.
// Accepts a start command with an element count, clears the datapath, streams
// A/B buffer read addresses, realigns the sum/compute enables to the buffer
// read latency, drains the accumulator pipeline and raises sticky status.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start/abort/ack     single-cycle commands from the register file
//   hold                suspends issue of new reads while high
//   vector_len          element count, sampled on an accepted start
//   rd_en/rd_addr       A/B vector buffer read port
//   dp_clr/dp_ldi       datapath clear / index load (one cycle per run)
//   dp_compute/dp_en_sum  per-element datapath enables, aligned to read data
//   busy/done/err_len/zero_len  status
module dot_product_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int RD_LAT       = 1,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              ack,
  input  logic              hold,
  input  logic [31:0]       vector_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              dp_clr,
  output logic              dp_ldi,
  output logic              dp_compute,
  output logic              dp_en_sum,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              zero_len
);

  // Counts must hold 2**ADDR_W itself, hence one extra bit over the address.
  localparam int          LEN_W   = ADDR_W + 1;
  localparam int          DRN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                dp_clr_q, dp_clr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_len_q, err_len_d;
  logic                zero_len_q, zero_len_d;
  logic                strobe;
  logic                issue;
  logic                busy_now;

  // Pipe tap is the returning-data strobe for both datapath enables.
  assign strobe = vld_pipe_q[RD_LAT-1];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    acc_cnt_d   = acc_cnt_q + LEN_W'(strobe);
    drain_cnt_d = drain_cnt_q;
    // rd_en feeds the pipe; in-flight data keeps moving regardless of hold.
    vld_pipe_d  = (vld_pipe_q << 1) | RD_LAT'(rd_en_q);
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    err_len_d   = err_len_q;
    zero_len_d  = zero_len_q;
    issue       = 1'b0;
    busy_now    = (state_q == S_CLEAR) || (state_q == S_FETCH) || (state_q == S_DRAIN);

    case (state_q)
      S_IDLE, S_DONE: begin
        // start outranks ack when both arrive in DONE
        if (start) begin
          len_d       = vector_len[LEN_W-1:0];
          err_len_d   = 1'b0;
          zero_len_d  = 1'b0;
          issue_cnt_d = '0;
          acc_cnt_d   = '0;
          drain_cnt_d = '0;
          if (vector_len == 32'd0) begin
            zero_len_d = 1'b1;
            state_d    = S_DONE;
          end else if (vector_len > MAX_LEN) begin
            err_len_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_CLEAR;
          end
        end else if (state_q == S_DONE && ack) begin
          state_d    = S_IDLE;
          err_len_d  = 1'b0;
          zero_len_d = 1'b0;
        end
      end
      // Outputs are registered, so the issue decision made while the clear
      // pulse is on the wire puts address 0 out on the first FETCH cycle.
      S_CLEAR, S_FETCH: begin
        if (!hold) begin
          issue       = 1'b1;
          rd_en_d     = 1'b1;
          rd_addr_d   = issue_cnt_q[ADDR_W-1:0];
          issue_cnt_d = issue_cnt_q + LEN_W'(1);
        end
        // Terminate on the full-width count; rd_addr wraps at 2**ADDR_W.
        if (issue && issue_cnt_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
        else                                           state_d = S_FETCH;
      end
      S_DRAIN: begin
        if (acc_cnt_q == len_q) begin
          if (int'(drain_cnt_q) >= DRAIN_CYCLES - 1) state_d = S_DONE;
          else                                       drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort only acts on a live run and kills all in-flight strobes
    if (abort && busy_now) begin
      state_d    = S_IDLE;
      rd_en_d    = 1'b0;
      vld_pipe_d = '0;
    end

    dp_clr_d = (state_d == S_CLEAR);
    busy_d   = (state_d == S_CLEAR) || (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      drain_cnt_q <= '0;
      vld_pipe_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      dp_clr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      zero_len_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      dp_clr_q    <= dp_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      zero_len_q  <= zero_len_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign dp_clr     = dp_clr_q;
  assign dp_ldi     = dp_clr_q;
  assign dp_compute = strobe;
  assign dp_en_sum  = strobe;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_len    = err_len_q;
  assign zero_len   = zero_len_q;

endmodule
